// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector family.
// Latency: none (types and combinational helper only). Backpressure: not applicable.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } seq_det_state_t;

  localparam int MASK_W = 32;

  // Mask with the low 'len' bits set. Callers truncate the result to their pattern width.
  function automatic logic [MASK_W-1:0] len_mask(input logic [MASK_W-1:0] len);
    if (len >= MASK_W)
      return '1;
    else
      return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Bit stream, configuration and status bundle of the pattern detector.
// Latency: none (wiring only). Backpressure: none; the source drives one bit per in_valid cycle.
interface seq_pattern_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 8
);
  logic               in_valid;
  logic               x;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               armed;

  modport master (
    output in_valid, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  match, match_count, cfg_err, armed
  );

  modport slave (
    input  in_valid, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output match, match_count, cfg_err, armed
  );
endinterface

// File: rtl/seq_det_match_counter.sv
// Saturating event counter; clear has priority but a same-cycle increment still lands (result 1).
// Latency: 1 cycle. Backpressure: none.
module seq_det_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt <= '0;
    else if (clr)
      cnt <= inc ? CNT_W'(1) : '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector, overlapping or non-overlapping.
// Latency: match registered 1 cycle after the last pattern bit. Backpressure: none; bits sampled on in_valid.
module seq_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seq_pattern_detector_if.slave bus
);
  import seq_det_pkg::*;

  seq_det_state_t     state, state_nxt;
  logic [MAX_LEN-1:0] hist, hist_nxt;
  logic [MAX_LEN-1:0] pat, pat_nxt;
  logic [LEN_W-1:0]   fill, fill_nxt;
  logic [LEN_W-1:0]   len, len_nxt;
  logic               ovl, ovl_nxt;
  logic               match_q, match_nxt;
  logic               err_q, err_nxt;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN:0]   cand;
  logic [LEN_W-1:0]   fill_inc;
  logic               legal;
  logic               shift;
  logic               hit;

  assign mask     = MAX_LEN'(len_mask(MASK_W'(len)));
  assign cand     = {hist, bus.x};
  assign fill_inc = (fill < len) ? fill + LEN_W'(1) : fill;
  assign legal    = (bus.cfg_len != '0) && (int'(bus.cfg_len) <= MAX_LEN);
  // A load in the same cycle always wins, so the bit is dropped even if the load is rejected.
  assign shift    = bus.in_valid && !bus.cfg_load && (state != IDLE);
  assign hit      = shift && (fill_inc == len) &&
                    ((cand & {1'b0, mask}) == {1'b0, pat & mask});

  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    pat_nxt   = pat;
    fill_nxt  = fill;
    len_nxt   = len;
    ovl_nxt   = ovl;
    match_nxt = 1'b0;
    err_nxt   = 1'b0;

    if (bus.cfg_load) begin
      if (legal) begin
        pat_nxt   = bus.cfg_pattern;
        len_nxt   = bus.cfg_len;
        ovl_nxt   = bus.cfg_overlap;
        hist_nxt  = '0;
        fill_nxt  = '0;
        state_nxt = FILL;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (shift) begin
      hist_nxt = cand[MAX_LEN-1:0];
      fill_nxt = fill_inc;
      if (hit) begin
        match_nxt = 1'b1;
        if (ovl) begin
          state_nxt = HUNT;
        end else begin
          fill_nxt  = '0;
          state_nxt = FILL;
        end
      end else if (fill_inc == len) begin
        state_nxt = HUNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      hist    <= '0;
      pat     <= '0;
      fill    <= '0;
      len     <= '0;
      ovl     <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      hist    <= hist_nxt;
      pat     <= pat_nxt;
      fill    <= fill_nxt;
      len     <= len_nxt;
      ovl     <= ovl_nxt;
      match_q <= match_nxt;
      err_q   <= err_nxt;
    end
  end

  seq_det_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bus.cnt_clr),
    .inc     (hit),
    .cnt     (bus.match_count)
  );

  assign bus.match   = match_q;
  assign bus.cfg_err = err_q;
  assign bus.armed   = (state != IDLE);

endmodule
